// File: rtl/test_pattern_engine.sv
// VGA test pattern source: frame-synchronous pattern select with auto-cycle mode, 2-stage pipeline.
// Optional crosshair overlay enabled by defining TPG_CROSSHAIR_EN.
module test_pattern_engine #(
  parameter int unsigned COLOR_BITS   = 3,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned BORDER_WIDTH = 8,
  parameter int unsigned CHECKER_LOG2 = 5,
  parameter int unsigned AUTO_FRAMES  = 120
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_pattern,
  input  logic                  i_auto,
  input  logic [9:0]            i_hpos,
  input  logic [9:0]            i_vpos,
  input  logic                  i_visible,
  input  logic                  i_frame_strobe,
  output logic [COLOR_BITS-1:0] o_red_video,
  output logic [COLOR_BITS-1:0] o_grn_video,
  output logic [COLOR_BITS-1:0] o_blu_video,
  output logic                  o_visible,
  output logic [3:0]            o_active_pattern,
  output logic                  o_pattern_change
);

  localparam int unsigned FcW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(AUTO_FRAMES - 1);
  localparam logic [9:0] HVis = 10'(H_VISIBLE);
  localparam logic [9:0] BarW = 10'(H_VISIBLE / 8);
  localparam logic [9:0] Bw   = 10'(BORDER_WIDTH);
  localparam logic [9:0] HBrd = 10'(H_VISIBLE - BORDER_WIDTH);
  localparam logic [9:0] VBrd = 10'(V_VISIBLE - BORDER_WIDTH);
  localparam logic [COLOR_BITS-1:0] Full = {COLOR_BITS{1'b1}};

  typedef enum logic [0:0] {StManual, StAuto} state_e;

  state_e         state_q, state_d;
  logic [3:0]     active_q, active_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic [7:0]     scroll_q, scroll_d;
  logic           change_q;

  // Mode state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StManual;
      active_q <= 4'd0;
      fc_q     <= '0;
      scroll_q <= 8'd0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      fc_q     <= fc_d;
      scroll_q <= scroll_d;
      change_q <= (active_d != active_q);
    end
  end

  // Next-state: everything holds unless a frame strobe arrives
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    fc_d     = fc_q;
    scroll_d = scroll_q;
    if (i_frame_strobe) begin
      scroll_d = scroll_q + 8'd1;
      unique case (state_q)
        StManual: begin
          if (i_auto) begin
            state_d  = StAuto;
            active_d = 4'd1;
            fc_d     = '0;
          end else begin
            active_d = i_pattern;
          end
        end
        StAuto: begin
          if (!i_auto) begin
            state_d  = StManual;
            active_d = i_pattern;
          end else if (fc_q == FcLast) begin
            fc_d     = '0;
            active_d = (active_q == 4'd7) ? 4'd1 : active_q + 4'd1;
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
        default: state_d = StManual;
      endcase
    end
  end

  // Stage 1: raw pattern colour
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;
  logic [7:0]            ramp;
  logic [2:0]            bar;
  logic                  border;

  always_comb begin
    ramp   = i_hpos[7:0] + scroll_q;
    bar    = 3'(i_hpos / BarW);
    border = (i_hpos < Bw) || (i_hpos >= HBrd) || (i_vpos < Bw) || (i_vpos >= VBrd);
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    case (active_q)
      4'd1: pix_r = Full;
      4'd2: pix_g = Full;
      4'd3: pix_b = Full;
      4'd4: begin
        if (i_hpos < HVis) begin
          pix_r = {COLOR_BITS{~bar[1]}};
          pix_g = {COLOR_BITS{~bar[2]}};
          pix_b = {COLOR_BITS{~bar[0]}};
        end
      end
      4'd5: begin
        if (border) begin
          pix_r = Full;
          pix_g = Full;
          pix_b = Full;
        end
      end
      4'd6: begin
        if (i_hpos[CHECKER_LOG2] ^ i_vpos[CHECKER_LOG2]) begin
          pix_r = Full;
          pix_g = Full;
          pix_b = Full;
        end
      end
      4'd7: begin
        pix_r = ramp[7 -: COLOR_BITS];
        pix_g = ramp[7 -: COLOR_BITS];
        pix_b = ramp[7 -: COLOR_BITS];
      end
      default: ;
    endcase
  end

  logic [COLOR_BITS-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic                  s1_vis_q;
  logic [COLOR_BITS-1:0] s2_r_q, s2_g_q, s2_b_q, s2_r_d, s2_g_d, s2_b_d;
  logic                  s2_vis_q;

`ifdef TPG_CROSSHAIR_EN
  localparam logic [9:0] HMid = 10'(H_VISIBLE / 2);
  localparam logic [9:0] VMid = 10'(V_VISIBLE / 2);
  logic [9:0] s1_hpos_q, s1_vpos_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_hpos_q <= 10'd0;
      s1_vpos_q <= 10'd0;
    end else begin
      s1_hpos_q <= i_hpos;
      s1_vpos_q <= i_vpos;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s1_vis_q <= 1'b0;
      s2_r_q   <= '0;
      s2_g_q   <= '0;
      s2_b_q   <= '0;
      s2_vis_q <= 1'b0;
    end else begin
      s1_r_q   <= pix_r;
      s1_g_q   <= pix_g;
      s1_b_q   <= pix_b;
      s1_vis_q <= i_visible;
      s2_r_q   <= s2_r_d;
      s2_g_q   <= s2_g_d;
      s2_b_q   <= s2_b_d;
      s2_vis_q <= s1_vis_q;
    end
  end

  // Stage 2: blank outside the visible area, then optional overlay
  always_comb begin
    s2_r_d = s1_vis_q ? s1_r_q : '0;
    s2_g_d = s1_vis_q ? s1_g_q : '0;
    s2_b_d = s1_vis_q ? s1_b_q : '0;
`ifdef TPG_CROSSHAIR_EN
    if (s1_vis_q && ((s1_hpos_q == HMid) || (s1_vpos_q == VMid))) begin
      s2_r_d = Full;
      s2_g_d = Full;
      s2_b_d = Full;
    end
`endif
  end

  always_comb begin
    o_red_video      = s2_r_q;
    o_grn_video      = s2_g_q;
    o_blu_video      = s2_b_q;
    o_visible        = s2_vis_q;
    o_active_pattern = active_q;
    o_pattern_change = change_q;
  end

endmodule

// File: tb/tb_test_pattern_engine.sv
// Scoreboard bench for test_pattern_engine: expected pixels queued at drive time, popped at output.
module tb_test_pattern_engine;

  localparam int CB = 4;
  localparam int HV = 640;
  localparam int VV = 480;
  localparam int BW = 8;
  localparam int CL = 5;
  localparam int AF = 2;
  localparam int PW = 3 * CB + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_pattern;
  logic          i_auto;
  logic [9:0]    i_hpos;
  logic [9:0]    i_vpos;
  logic          i_visible;
  logic          i_frame_strobe;
  logic [CB-1:0] o_red_video;
  logic [CB-1:0] o_grn_video;
  logic [CB-1:0] o_blu_video;
  logic          o_visible;
  logic [3:0]    o_active_pattern;
  logic          o_pattern_change;

  test_pattern_engine #(
    .COLOR_BITS  (CB),
    .H_VISIBLE   (HV),
    .V_VISIBLE   (VV),
    .BORDER_WIDTH(BW),
    .CHECKER_LOG2(CL),
    .AUTO_FRAMES (AF)
  ) u_dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_pattern       (i_pattern),
    .i_auto          (i_auto),
    .i_hpos          (i_hpos),
    .i_vpos          (i_vpos),
    .i_visible       (i_visible),
    .i_frame_strobe  (i_frame_strobe),
    .o_red_video     (o_red_video),
    .o_grn_video     (o_grn_video),
    .o_blu_video     (o_blu_video),
    .o_visible       (o_visible),
    .o_active_pattern(o_active_pattern),
    .o_pattern_change(o_pattern_change)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_auto_st;
  logic [3:0] m_act;
  int         m_fc;
  logic [7:0] m_scr;
  logic       m_chg;
  logic [PW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] exp_pix(int h, int v, logic vis, logic [3:0] act,
                                            logic [7:0] scr);
    logic [CB-1:0] r, g, b, full;
    logic [7:0]    s;
    int            bar;
    full = '1;
    r = '0;
    g = '0;
    b = '0;
    case (act)
      4'd1: r = full;
      4'd2: g = full;
      4'd3: b = full;
      4'd4: begin
        if (h < HV) begin
          bar = h / (HV / 8);
          r = bar[1] ? '0 : full;
          g = bar[2] ? '0 : full;
          b = bar[0] ? '0 : full;
        end
      end
      4'd5: begin
        if (h < BW || h >= HV - BW || v < BW || v >= VV - BW) begin
          r = full;
          g = full;
          b = full;
        end
      end
      4'd6: begin
        if ((((h >> CL) ^ (v >> CL)) & 1) == 1) begin
          r = full;
          g = full;
          b = full;
        end
      end
      4'd7: begin
        s = 8'(h) + scr;
        r = CB'(s >> (8 - CB));
        g = r;
        b = r;
      end
      default: ;
    endcase
    if (!vis) begin
      r = '0;
      g = '0;
      b = '0;
    end
`ifdef TPG_CROSSHAIR_EN
    if (vis && (h == HV / 2 || v == VV / 2)) begin
      r = full;
      g = full;
      b = full;
    end
`endif
    return {r, g, b, vis};
  endfunction

  task automatic model_reset();
    m_auto_st = 1'b0;
    m_act     = 4'd0;
    m_fc      = 0;
    m_scr     = 8'd0;
    m_chg     = 1'b0;
  endtask

  task automatic step(input int h, input int v, input logic vis, input logic strb,
                      input logic [3:0] pat, input logic au);
    logic [3:0]    old_act;
    logic [PW-1:0] exp;
    i_hpos         = 10'(h);
    i_vpos         = 10'(v);
    i_visible      = vis;
    i_frame_strobe = strb;
    i_pattern      = pat;
    i_auto         = au;
    exp_q.push_back(exp_pix(h, v, vis, m_act, m_scr));
    old_act = m_act;
    if (strb) begin
      m_scr = m_scr + 8'd1;
      if (!m_auto_st) begin
        if (au) begin
          m_auto_st = 1'b1;
          m_act     = 4'd1;
          m_fc      = 0;
        end else begin
          m_act = pat;
        end
      end else if (!au) begin
        m_auto_st = 1'b0;
        m_act     = pat;
      end else if (m_fc == AF - 1) begin
        m_fc  = 0;
        m_act = (m_act == 4'd7) ? 4'd1 : m_act + 4'd1;
      end else begin
        m_fc = m_fc + 1;
      end
    end
    m_chg = (m_act != old_act);
    @(posedge i_clk);
    #1;
    exp = exp_q.pop_front();
    check_eq("pix", 32'({o_red_video, o_grn_video, o_blu_video, o_visible}), 32'(exp));
    check_eq("active", 32'(o_active_pattern), 32'(m_act));
    check_eq("change", 32'(o_pattern_change), 32'(m_chg));
  endtask

  task automatic run_rand(input int n, input logic [3:0] pat, input logic au);
    for (int i = 0; i < n; i++) begin
      step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
           1'($urandom_range(0, 1)), 1'b0, pat, au);
    end
  endtask

  // Reset with whatever pixel inputs are currently applied
  task automatic do_reset();
    i_rst          = 1'b1;
    i_frame_strobe = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("rst_pix", 32'({o_red_video, o_grn_video, o_blu_video, o_visible}), 32'd0);
    check_eq("rst_active", 32'(o_active_pattern), 32'd0);
    check_eq("rst_change", 32'(o_pattern_change), 32'd0);
    i_rst = 1'b0;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  initial begin
    i_rst          = 1'b1;
    i_pattern      = 4'd0;
    i_auto         = 1'b0;
    i_hpos         = 10'd0;
    i_vpos         = 10'd0;
    i_visible      = 1'b0;
    i_frame_strobe = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    do_reset();

    // Black after reset, visible delayed by two
    run_rand(10, 4'd0, 1'b0);
    step(5, 5, 1'b1, 1'b1, 4'd0, 1'b0);
    run_rand(3, 4'd0, 1'b0);

    // Colour bars
    step(0, 0, 1'b1, 1'b1, 4'd4, 1'b0);
    step(0, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    step(100, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    step(639, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    step(640, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    step(79, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    step(80, 10, 1'b1, 1'b0, 4'd4, 1'b0);
    for (int k = 0; k < 8; k++) step(k * 80 + 40, 20, 1'b1, 1'b0, 4'd4, 1'b0);
    run_rand(6, 4'd4, 1'b0);

    // Red, then a mid-frame request for green held off until the strobe
    step(1, 1, 1'b1, 1'b1, 4'd1, 1'b0);
    run_rand(5, 4'd1, 1'b0);
    run_rand(5, 4'd2, 1'b0);
    step(2, 2, 1'b1, 1'b1, 4'd2, 1'b0);
    run_rand(5, 4'd2, 1'b0);

    // Border edges
    step(0, 0, 1'b1, 1'b1, 4'd5, 1'b0);
    step(7, 200, 1'b1, 1'b0, 4'd5, 1'b0);
    step(8, 200, 1'b1, 1'b0, 4'd5, 1'b0);
    step(631, 200, 1'b1, 1'b0, 4'd5, 1'b0);
    step(632, 200, 1'b1, 1'b0, 4'd5, 1'b0);
    step(300, 7, 1'b1, 1'b0, 4'd5, 1'b0);
    step(300, 8, 1'b1, 1'b0, 4'd5, 1'b0);
    step(300, 471, 1'b1, 1'b0, 4'd5, 1'b0);
    step(300, 472, 1'b1, 1'b0, 4'd5, 1'b0);

    // Checkerboard
    step(0, 0, 1'b1, 1'b1, 4'd6, 1'b0);
    step(31, 0, 1'b1, 1'b0, 4'd6, 1'b0);
    step(32, 0, 1'b1, 1'b0, 4'd6, 1'b0);
    step(32, 32, 1'b1, 1'b0, 4'd6, 1'b0);
    run_rand(8, 4'd6, 1'b0);

    // Scrolling ramp, including a full scroll wrap
    step(0, 0, 1'b1, 1'b1, 4'd7, 1'b0);
    step(13, 0, 1'b1, 1'b0, 4'd7, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(int'($urandom_range(0, 639)), 0, 1'b1, 1'b1, 4'd7, 1'b0);
    end
    step(13, 0, 1'b1, 1'b0, 4'd7, 1'b0);
    step(255, 0, 1'b1, 1'b0, 4'd7, 1'b0);
    run_rand(4, 4'd7, 1'b0);

    // Undefined pattern codes
    for (int p = 8; p < 16; p++) begin
      step(0, 0, 1'b1, 1'b1, 4'(p), 1'b0);
      run_rand(2, 4'(p), 1'b0);
    end

    // Auto-cycle through a full wrap, then back to manual
    for (int i = 0; i < 20; i++) begin
      step(int'($urandom_range(0, 639)), 5, 1'b1, 1'b1, 4'd0, 1'b1);
      run_rand(1, 4'd3, 1'b1);
    end
    step(0, 0, 1'b1, 1'b1, 4'd5, 1'b0);
    run_rand(3, 4'd5, 1'b0);

    // Reset mid-frame while in auto, then auto restarts at pattern 1
    for (int i = 0; i < 5; i++) step(10, 10, 1'b1, 1'b1, 4'd0, 1'b1);
    run_rand(3, 4'd0, 1'b1);
    i_hpos    = 10'd100;
    i_vpos    = 10'd50;
    i_visible = 1'b1;
    do_reset();
    step(0, 0, 1'b1, 1'b1, 4'd0, 1'b1);
    step(320, 100, 1'b1, 1'b0, 4'd0, 1'b1);
    step(100, 240, 1'b1, 1'b0, 4'd0, 1'b1);
    step(320, 100, 1'b0, 1'b0, 4'd0, 1'b1);
    run_rand(4, 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_engine.md
Name: test_pattern_engine

Overview:
Parametrised VGA test pattern source for the video pipeline. It sits between the sync/position counter and the VGA output registers. Compared with the fixed 3-bit generator, it adds configurable colour depth and geometry and a 2-stage pipeline with a matched visible flag. Pattern switches are frame-synchronous, and an auto-cycle mode steps through the patterns every N frames.

Parameters:
COLOR_BITS, 3, bits per colour channel (1..8)
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BORDER_WIDTH, 8, border thickness in pixels/lines (pattern 5)
CHECKER_LOG2, 5, checker cell size = 2**CHECKER_LOG2 pixels (pattern 6)
AUTO_FRAMES, 120, frames per pattern in auto mode (>=1)

Ports:
i_clk  in  1  pixel clock, sole clock
i_rst  in  1  synchronous reset, active-high
i_pattern  in  4  requested pattern, sampled only on i_frame_strobe
i_auto  in  1  1 = auto-cycle mode, sampled only on i_frame_strobe
i_hpos  in  10  current pixel column
i_vpos  in  10  current line
i_visible  in  1  pixel is in visible area
i_frame_strobe  in  1  one-cycle pulse at start of frame
o_red_video  out  COLOR_BITS  red
o_grn_video  out  COLOR_BITS  green
o_blu_video  out  COLOR_BITS  blue
o_visible  out  1  i_visible delayed to align with colour outputs
o_active_pattern  out  4  pattern currently rendered
o_pattern_change  out  1  one-cycle pulse when o_active_pattern changes

Behaviour:
- Reset (i_rst high at a clock edge): all outputs 0; state MANUAL; active pattern 0; frame counter 0; scroll counter 0; pipeline registers 0. Reset mid-frame takes effect on the next edge, with no partial output.
- FULL = all-ones of COLOR_BITS.
- Pattern set: 0 black; 1 red FULL; 2 green FULL; 3 blue FULL.
- Pattern 4 colour bars: bar b = i_hpos/(H_VISIBLE/8), giving 0..7. R=~b[1], G=~b[2], B=~b[0], each replicated to FULL. Order is white, yellow, cyan, green, magenta, red, blue, black. i_hpos>=H_VISIBLE -> black.
- Pattern 5: white (FULL) when i_hpos<BORDER_WIDTH, i_hpos>=H_VISIBLE-BORDER_WIDTH, i_vpos<BORDER_WIDTH or i_vpos>=V_VISIBLE-BORDER_WIDTH. Black elsewhere.
- Pattern 6: white when i_hpos[CHECKER_LOG2]^i_vpos[CHECKER_LOG2]=1, else black.
- Pattern 7 scrolling grey ramp: s = (i_hpos[7:0] + scroll) mod 256, an 8-bit wrap. All channels = s[7:8-COLOR_BITS].
- Pattern values 8..15 render black.
- Scroll counter: 8 bits, +1 on every i_frame_strobe, wraps 255->0. It runs in both modes.
- Mode FSM, evaluated only on cycles with i_frame_strobe=1:
  - MANUAL, i_auto=0: active <= i_pattern.
  - MANUAL, i_auto=1: go to AUTO; active <= 1; frame counter <= 0.
  - AUTO, i_auto=0: go to MANUAL; active <= i_pattern.
  - AUTO, i_auto=1: if frame counter==AUTO_FRAMES-1, counter <= 0 and active <= active+1, wrapping 7->1 (0 is skipped). Otherwise counter+1.
  - With no strobe, state, active pattern and counters hold. i_pattern/i_auto changes mid-frame are ignored.
- o_active_pattern reflects the active register, so it updates at the edge that samples the strobe.
- o_pattern_change: high for exactly one cycle, the cycle after active changes value. No pulse if the reloaded value is unchanged.
- Pipeline latency is 2 cycles. Stage 1 registers the raw pattern colour from i_hpos/i_vpos/active/scroll and delays i_visible. Stage 2 registers the outputs, forcing colour to 0 when the delayed visible flag is 0, and drives o_visible. Inputs presented before edge N appear on outputs after edge N+1.
- The new pattern applies to pixels whose positions enter stage 1 at or after the edge that loads it.

Optional Feature:
TPG_CROSSHAIR_EN.
- Defined: stage 2 overrides colour with FULL white on all channels when the aligned position satisfies hpos==H_VISIBLE/2 or vpos==V_VISIBLE/2 and the pixel is visible. Hpos/vpos are delayed through stage 1 for this. This applies for every pattern, including 0; latency is unchanged.
- Undefined: no overlay and no extra position delay registers.

Test Plan:
- Reset then run with i_pattern=0: all colour outputs 0, o_visible tracks i_visible delayed by 2, o_active_pattern=0, no o_pattern_change pulse.
- COLOR_BITS=3, i_pattern=4 latched on strobe: hpos=0 -> (7,7,7); hpos=100 -> (7,7,0); hpos=639 -> (0,0,0). o_pattern_change pulses once.
- i_pattern changed 1->2 mid-frame: output stays red until the next strobe, then green 2 cycles after the first post-strobe pixel. i_visible=0 pixels output 0.
- COLOR_BITS=4, pattern 7: after 3 strobes, scroll=3; hpos=13 gives s=16 -> output 1 on all channels. Running 256 strobes wraps scroll back to 3.
- AUTO_FRAMES=2, i_auto=1: active goes 1 at the first strobe, then 2, 3, …, 7, 1 at every second strobe after that, with one o_pattern_change per step. Dropping i_auto with i_pattern=5 gives active=5 at the next strobe.
- i_rst asserted in AUTO mid-frame: the next cycle shows outputs 0, active 0, MANUAL. A following strobe with i_auto=1 restarts at pattern 1; with TPG_CROSSHAIR_EN, hpos=320 visible shows white.
